// File: rtl/pc_sequencer.sv
// Fetch/decode/execute control sequencer for the 8-bit core.
// Registers only the state and the retired-instruction counter.
module pc_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             LoadPC,
   output logic             IncPC,
   output logic             LoadIR,
   output logic             LoadOp,
   output logic             LoadAcc,
   output logic [1:0]       alu_op,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             addr_sel,
   output logic             halted,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      DECODE   = 3'd2,
      FETCH_OP = 3'd3,
      EXEC     = 3'd4,
      MEM_RD   = 3'd5,
      MEM_WR   = 3'd6,
      HALT     = 3'd7
   } state_t;

   state_t cur, nxt;
   logic   retire;

   logic op_lda, op_sta, op_add, op_sub, op_jmp, op_jz, op_hlt;

   assign op_lda = (opcode == 4'd1);
   assign op_sta = (opcode == 4'd2);
   assign op_add = (opcode == 4'd3);
   assign op_sub = (opcode == 4'd4);
   assign op_jmp = (opcode == 4'd5);
   assign op_jz  = (opcode == 4'd6);
   assign op_hlt = (opcode == 4'd7);

   assign state = cur;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur         <= IDLE;
         instr_count <= '0;
      end else begin
         cur <= nxt;
         if (retire)
            instr_count <= instr_count + CNT_W'(1);
      end
   end

   always_comb begin
      nxt      = cur;
      retire   = 1'b0;
      LoadPC   = 1'b0;
      IncPC    = 1'b0;
      LoadIR   = 1'b0;
      LoadOp   = 1'b0;
      LoadAcc  = 1'b0;
      alu_op   = 2'b00;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      addr_sel = 1'b0;
      halted   = 1'b0;
      case (cur)
         IDLE: begin
            if (start)
               nxt = FETCH;
         end
         FETCH: begin
            mem_rd = 1'b1;
            if (mem_ready) begin
               LoadIR = 1'b1;
               IncPC  = 1'b1;
               nxt    = DECODE;
            end
         end
         DECODE: begin
            // Everything not listed (0 and 8-F) retires as a one-byte NOP.
            unique case (1'b1)
               op_hlt: begin
                  retire = 1'b1;
                  nxt    = HALT;
               end
               op_lda, op_sta, op_add,
               op_sub, op_jmp, op_jz:
                  nxt = FETCH_OP;
               default: begin
                  retire = 1'b1;
                  nxt    = FETCH;
               end
            endcase
         end
         FETCH_OP: begin
            mem_rd = 1'b1;
            if (mem_ready) begin
               LoadOp = 1'b1;
               IncPC  = 1'b1;
               nxt    = EXEC;
            end
         end
         EXEC: begin
            unique case (1'b1)
               op_jmp: begin
                  LoadPC = 1'b1;
                  retire = 1'b1;
                  nxt    = FETCH;
               end
               op_jz: begin
                  LoadPC = zero;
                  retire = 1'b1;
                  nxt    = FETCH;
               end
               op_sta:
                  nxt = MEM_WR;
               op_lda, op_add, op_sub:
                  nxt = MEM_RD;
               default: begin
                  retire = 1'b1;
                  nxt    = FETCH;
               end
            endcase
         end
         MEM_RD: begin
            mem_rd   = 1'b1;
            addr_sel = 1'b1;
            if (op_add)
               alu_op = 2'b01;
            else if (op_sub)
               alu_op = 2'b10;
            if (mem_ready) begin
               LoadAcc = 1'b1;
               retire  = 1'b1;
               nxt     = FETCH;
            end
         end
         MEM_WR: begin
            mem_wr   = 1'b1;
            addr_sel = 1'b1;
            if (mem_ready) begin
               retire = 1'b1;
               nxt    = FETCH;
            end
         end
         HALT: begin
            halted = 1'b1;
         end
         default: nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: instruction-level reference model,
// directed scenarios and a randomized run.
module tb_pc_sequencer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset, start, zero, mem_ready;
   logic [3:0]   opcode;
   logic         LoadPC, IncPC, LoadIR, LoadOp, LoadAcc;
   logic [1:0]   alu_op;
   logic         mem_rd, mem_wr, addr_sel, halted;
   logic [2:0]   state;
   logic [W-1:0] instr_count;
   logic [10:0]  ctrl;

   int nvec = 0;
   int nerr = 0;

   // model: mode 0 idle, 1 running, 2 halted; k = step within instruction
   int         mode, k, cnt;
   logic [3:0] cur_op;

   pc_sequencer #(.CNT_W(W)) dut (
      .clk(clk), .reset(reset), .start(start), .opcode(opcode),
      .zero(zero), .mem_ready(mem_ready), .LoadPC(LoadPC),
      .IncPC(IncPC), .LoadIR(LoadIR), .LoadOp(LoadOp),
      .LoadAcc(LoadAcc), .alu_op(alu_op), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .addr_sel(addr_sel), .halted(halted),
      .state(state), .instr_count(instr_count)
   );

   assign ctrl = {LoadPC, IncPC, LoadIR, LoadOp, LoadAcc, alu_op,
                  mem_rd, mem_wr, addr_sel, halted};

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  name, act, exp, $time);
      end
   endtask

   function automatic int ilen(input logic [3:0] op);
      if (op >= 4'd1 && op <= 4'd4) return 5;
      if (op == 4'd5 || op == 4'd6) return 4;
      return 2;
   endfunction

   // 1 fetch, 2 decode, 3 operand fetch, 4 exec, 5 read, 6 write
   function automatic int kind();
      if (k < 4) return k + 1;
      return (cur_op == 4'd2) ? 6 : 5;
   endfunction

   function automatic int exp_state();
      if (mode == 0) return 0;
      if (mode == 2) return 7;
      return kind();
   endfunction

   function automatic logic [10:0] exp_ctrl(input logic z, input logic r);
      logic lpc, inc, lir, lop, lacc, rd, wr, as, h;
      logic [1:0] alu;
      {lpc, inc, lir, lop, lacc, rd, wr, as, h} = '0;
      alu = 2'b00;
      if (mode == 2) h = 1'b1;
      else if (mode == 1) begin
         case (kind())
            1: begin rd = 1; lir = r; inc = r; end
            3: begin rd = 1; lop = r; inc = r; end
            4: lpc = (cur_op == 4'd5) || (cur_op == 4'd6 && z);
            5: begin
               rd = 1; as = 1; lacc = r;
               alu = (cur_op == 4'd3) ? 2'b01 :
                     (cur_op == 4'd4) ? 2'b10 : 2'b00;
            end
            6: begin wr = 1; as = 1; end
            default: ;
         endcase
      end
      return {lpc, inc, lir, lop, lacc, alu, rd, wr, as, h};
   endfunction

   task automatic advance(input logic s, input logic [3:0] op,
                          input logic r);
      int kd;
      if (mode == 0) begin
         if (s) begin mode = 1; k = 0; end
      end else if (mode == 1) begin
         kd = kind();
         if ((kd == 1 || kd == 3 || kd == 5 || kd == 6) && !r) return;
         if (kd == 1) cur_op = op;
         k++;
         if (k == ilen(cur_op)) begin
            cnt = (cnt + 1) % (1 << W);
            if (cur_op == 4'd7) mode = 2;
            else k = 0;
         end
      end
   endtask

   task automatic step(input logic s, input logic [3:0] op,
                       input logic z, input logic r);
      @(negedge clk);
      start     = s;
      zero      = z;
      mem_ready = r;
      opcode    = (mode == 1 && k >= 1) ? cur_op : op;
      #1;
      chk("state", state, exp_state());
      chk("ctrl", ctrl, exp_ctrl(z, r));
      chk("count", instr_count, cnt);
      chk("inv_pc", LoadPC & IncPC, 0);
      chk("inv_mem", mem_rd & mem_wr, 0);
      @(posedge clk);
      advance(s, op, r);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      #1;
      chk("rst_state", state, 0);
      chk("rst_ctrl", ctrl, 0);
      chk("rst_count", instr_count, 0);
      mode = 0; k = 0; cnt = 0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic run_op(input logic [3:0] op, input logic z);
      for (int i = 0; i < ilen(op); i++) step(1'b0, op, z, 1'b1);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; zero = 1'b0;
      mem_ready = 1'b0; opcode = 4'd0;
      mode = 0; k = 0; cnt = 0; cur_op = 4'd0;
      repeat (2) @(posedge clk);
      do_reset();

      // NOP, NOP, HLT with memory always ready
      step(1'b1, 4'd0, 1'b0, 1'b0);
      #1 chk("start_fetch", state, 1);
      run_op(4'd0, 1'b0);
      run_op(4'd0, 1'b0);
      run_op(4'd7, 1'b0);
      #1;
      chk("halt_state", state, 7);
      chk("halt_flag", halted, 1);
      chk("halt_count", instr_count, 3);
      repeat (3) step(1'b1, 4'd0, 1'b0, 1'b1);
      #1 chk("halt_sticky", state, 7);

      // LDA with a 3-cycle operand stall
      do_reset();
      step(1'b1, 4'd0, 1'b0, 1'b0);
      step(1'b0, 4'd1, 1'b0, 1'b1);
      step(1'b0, 4'd1, 1'b0, 1'b1);
      repeat (3) step(1'b0, 4'd1, 1'b0, 1'b0);
      repeat (3) step(1'b0, 4'd1, 1'b0, 1'b1);
      #1;
      chk("lda_count", instr_count, 1);
      chk("lda_state", state, 1);

      // second LDA parked in MEM_RD, then async reset
      step(1'b0, 4'd1, 1'b0, 1'b1);
      step(1'b0, 4'd1, 1'b0, 1'b1);
      step(1'b0, 4'd1, 1'b0, 1'b1);
      step(1'b0, 4'd1, 1'b0, 1'b1);
      step(1'b0, 4'd1, 1'b0, 1'b0);
      #1 chk("in_mem_rd", state, 5);
      do_reset();

      // branches and the remaining memory ops
      step(1'b1, 4'd0, 1'b0, 1'b0);
      run_op(4'd6, 1'b1);
      run_op(4'd6, 1'b0);
      run_op(4'd5, 1'b0);
      run_op(4'd2, 1'b0);
      run_op(4'd3, 1'b0);
      run_op(4'd4, 1'b0);
      #1 chk("mix_count", instr_count, 6);

      // counter wrap with a 4-bit counter
      do_reset();
      step(1'b1, 4'd0, 1'b0, 1'b0);
      for (int i = 0; i < 17; i++) run_op(4'($urandom_range(8, 15)), 1'b0);
      #1 chk("wrap_count", instr_count, 1);

      // randomized run
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if ((mode == 2 && $urandom_range(0, 3) == 0) ||
             $urandom_range(0, 299) == 0)
            do_reset();
         else
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 7));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
